mac_result_streamer: RTL

//  Downstream readout stage for the 8-bit signed MAC. Snapshots the 24-bit signed accumulator on request.

---
 rtl/mac_result_streamer_pkg.sv | 27 ++
 rtl/mac_result_streamer_if.sv | 33 +++
 rtl/mac_result_streamer_sat_clip.sv | 40 ++++
 rtl/mac_result_streamer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_result_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Package : mac_pkg
// Purpose : Shared constants and types for the MAC result streamer slice:
//           default accumulator/saturation widths, frame header magic
//           nibbles and the frame FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package mac_pkg;

  localparam int ACC_W_DEFAULT = 24;
  localparam int SAT_W_DEFAULT = 16;

  // Upper nibble of the header byte tells the consumer whether the payload
  // is the raw accumulator or the saturated (narrower) result.
  localparam logic [3:0] HDR_RAW = 4'hA;
  localparam logic [3:0] HDR_SAT = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Interface : mac_result_streamer_if
// Purpose   : Byte-stream valid/ready channel carrying result frames.
// Signals   : out_data  [7:0] frame byte (master -> slave)
//             out_valid       byte valid (master -> slave)
//             out_last        final byte of frame (master -> slave)
//             out_ready       byte accepted when valid & ready (slave -> master)
// Revision  : 1.0 - initial release
// ============================================================================
interface mac_result_streamer_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/mac_result_streamer_sat_clip.sv
`default_nettype none
// ============================================================================
// Module  : mac_sat_clip
// Purpose : Combinational signed saturation of an IN_W-bit value to OUT_W
//           bits. Values above the OUT_W signed maximum clip to the maximum,
//           values below the signed minimum clip to the minimum, anything
//           else is passed through truncated.
// Ports   : in_val  [IN_W-1:0]  signed input
//           out_val [OUT_W-1:0] signed saturated output
// Params  : IN_W >= OUT_W
// Revision: 1.0 - initial release
// ============================================================================
module mac_sat_clip #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_val,
  output logic [OUT_W-1:0] out_val
);

  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  // The value fits in OUT_W signed bits exactly when every bit from the
  // OUT_W sign position upward is a copy of the input sign bit.
  logic [IN_W-OUT_W:0] top_bits;
  logic                fits;

  assign top_bits = in_val[IN_W-1:OUT_W-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  always_comb begin
    out_val = in_val[OUT_W-1:0];
    if (!fits) begin
      out_val = in_val[IN_W-1] ? MIN_V : MAX_V;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_result_streamer.sv
`default_nettype none
// ============================================================================
// Module  : mac_result_streamer
// Purpose : Readout stage for the signed MAC. On cap_req the accumulator is
//           snapshotted and streamed as a byte frame:
//             header {magic, seq}, data bytes LSB first, XOR checksum.
//           The accumulator may keep running while the snapshot drains.
// Ports   : clk        clock, rising edge
//           rst_n      synchronous active-low reset
//           acc_in     [ACC_W-1:0] signed accumulator value
//           cap_req    snapshot request / frame start
//           clr_ovr    clear sticky overrun flag
//           out_if     byte stream (master): out_data/out_valid/out_last,
//                      out_ready
//           busy       frame in progress
//           overrun    sticky: cap_req seen while a frame was in progress
//           seq        [3:0] sequence number of next/current frame
// Config  : MAC_RESULT_SAT_EN - when defined, the snapshot is acc_in
//           saturated to SAT_W signed bits, the frame carries SAT_W/8 data
//           bytes and the header magic is HDR_SAT. Otherwise the full ACC_W
//           snapshot is sent with HDR_RAW and no clipping logic exists.
// Revision: 1.0 - initial release
// ============================================================================
module mac_result_streamer
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int SAT_W = SAT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACC_W-1:0]      acc_in,
  input  logic                  cap_req,
  input  logic                  clr_ovr,
  mac_result_streamer_if.master out_if,
  output logic                  busy,
  output logic                  overrun,
  output logic [3:0]            seq
);

`ifdef MAC_RESULT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int         SNAP_W    = SAT_EN ? SAT_W : ACC_W;
  localparam int         NB        = SNAP_W / 8;
  localparam int         IDX_W     = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [3:0] HDR_MAGIC = SAT_EN ? HDR_SAT : HDR_RAW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  // --------------------------------------------------------------------------
  // Snapshot source: raw accumulator or its saturated form
  // --------------------------------------------------------------------------
  logic [SNAP_W-1:0] snap_src;

`ifdef MAC_RESULT_SAT_EN
  mac_sat_clip #(
    .IN_W  (ACC_W),
    .OUT_W (SNAP_W)
  ) u_sat_clip (
    .in_val  (acc_in),
    .out_val (snap_src)
  );
`else
  assign snap_src = acc_in;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [SNAP_W-1:0]  snap_q,  snap_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [7:0]         csum_q,  csum_d;
  logic [3:0]         seq_q,   seq_d;
  logic               ovr_q,   ovr_d;

  logic               valid_int;
  logic               hs;
  logic               capture;
  logic               ovr_set;
  logic [7:0]         hdr_byte;
  logic [7:0]         data_byte;
  logic [7:0]         out_byte;

  assign valid_int = (state_q != IDLE);
  assign hs        = valid_int & out_if.out_ready;
  assign hdr_byte  = {HDR_MAGIC, seq_q};

  // A request is taken when idle, or on the checksum handshake so that a
  // new frame follows the previous one without an idle cycle.
  assign capture = cap_req & ((state_q == IDLE) | ((state_q == CSUM) & hs));
  assign ovr_set = cap_req & (state_q != IDLE) & ~((state_q == CSUM) & hs);

  // Current data byte selected by the byte index.
  always_comb begin
    data_byte = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (idx_q == IDX_W'(k)) begin
        data_byte = snap_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    out_byte = 8'h00;
    case (state_q)
      HDR:     out_byte = hdr_byte;
      DATA:    out_byte = data_byte;
      CSUM:    out_byte = csum_q;
      default: out_byte = 8'h00;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cap_req) state_d = HDR;
      HDR:  if (hs) state_d = DATA;
      DATA: if (hs && (idx_q == LAST_IDX)) state_d = CSUM;
      CSUM: if (hs) state_d = cap_req ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    out_if.out_valid = valid_int;
    out_if.out_data  = out_byte;
    out_if.out_last  = (state_q == CSUM);
    busy             = valid_int;
    overrun          = ovr_q;
    seq              = seq_q;
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    csum_d = csum_q;
    seq_d  = seq_q;
    ovr_d  = ovr_q;

    if (capture) begin
      snap_d = snap_src;
    end

    // Checksum is seeded with the header and folds in each data byte as it
    // is accepted, so it is complete by the time CSUM is presented.
    if (hs && (state_q == HDR)) begin
      idx_d  = '0;
      csum_d = hdr_byte;
    end else if (hs && (state_q == DATA)) begin
      idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      csum_d = csum_q ^ data_byte;
    end

    if (hs && (state_q == CSUM)) begin
      seq_d = seq_q + 4'd1;
    end

    // Setting has priority over clearing.
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q <= '0;
      idx_q  <= '0;
      csum_q <= 8'h00;
      seq_q  <= 4'd0;
      ovr_q  <= 1'b0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
      csum_q <= csum_d;
      seq_q  <= seq_d;
      ovr_q  <= ovr_d;
    end
  end

endmodule
`default_nettype wire
